// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate enable, x/y counters,
// programmable-polarity syncs, visible window and line/frame start strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 11,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 32,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          pix_en_o,
  output logic [CW-1:0] pos_x_o,
  output logic [CW-1:0] pos_y_o,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          video_on_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic          run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          pix_en_q, pix_en_d;
  logic          h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Next state; outputs are decoded from the next-state counters so they
  // line up with the pos_* values registered on the same edge.
  always_comb begin
    run_d         = en_i;
    div_d         = '0;
    x_d           = '0;
    y_d           = '0;
    pix_en_d      = 1'b0;
    h_sync_d      = ~H_POL;
    v_sync_d      = ~V_POL;
    video_on_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en_i) begin
      x_d = x_q;
      y_d = y_q;
      // First enabled edge restarts the divider at 0 rather than advancing it.
      if (run_q && div_q != DIV_LAST) begin
        div_d = div_q + DW'(1);
      end
      if (pix_en_q) begin
        if (x_q == CW'(H_TOTAL - 1)) begin
          x_d = '0;
          y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
        end else begin
          x_d = x_q + CW'(1);
        end
      end
      pix_en_d      = (div_d == DIV_LAST);
      h_sync_d      = (x_d >= CW'(HS_START) && x_d < CW'(HS_END)) ? H_POL : ~H_POL;
      v_sync_d      = (y_d >= CW'(VS_START) && y_d < CW'(VS_END)) ? V_POL : ~V_POL;
      video_on_d    = (x_d < CW'(H_ACTIVE)) && (y_d < CW'(V_ACTIVE));
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q         <= 1'b0;
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_en_q      <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_en_q      <= pix_en_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en_o      = pix_en_q;
  assign pos_x_o       = x_q;
  assign pos_y_o       = y_q;
  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign video_on_o    = video_on_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule
